// File: rtl/mux_rr_n.sv
// N-channel W-bit stream mux with round-robin arbitration and a registered one-beat output stage.
// Define MUX_FIXED_PRIO_EN to swap round-robin for fixed lowest-index-wins priority.
module mux_rr_n #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*W-1:0]     in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [W-1:0]       out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_sel
);

  logic             r_out_valid;
  logic [W-1:0]     r_out_data;
  logic [SEL_W-1:0] r_out_sel;

  logic             w_load_en;
  logic             w_gnt_vld;
  logic             w_xfer;
  logic [SEL_W-1:0] w_gnt;
  logic [SEL_W-1:0] w_base;
  logic [W-1:0]     w_data;

`ifdef MUX_FIXED_PRIO_EN
  assign w_base = '0;
`else
  logic [SEL_W-1:0] r_ptr;

  // Pointer moves to the slot after the winner, only when a beat actually transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_ptr <= '0;
    else if (w_xfer) r_ptr <= (w_gnt == SEL_W'(N-1)) ? '0 : w_gnt + 1'b1;
  end

  assign w_base = r_ptr;
`endif

  // Scan from the highest offset down so the lowest offset from w_base wins.
  always_comb begin
    int v_idx;
    v_idx     = 0;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int k = N-1; k >= 0; k--) begin
      v_idx = (int'(w_base) + k) % N;
      if (in_valid[v_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = SEL_W'(v_idx);
      end
    end
  end

  assign w_load_en = ~r_out_valid | out_ready;
  assign w_xfer    = w_gnt_vld & w_load_en;
  assign w_data    = in_data[w_gnt*W +: W];

  always_comb begin
    in_ready = '0;
    if (w_xfer) in_ready[w_gnt] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_sel   <= w_gnt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux_rr_n.sv
// Randomised scoreboard bench for mux_rr_n: a channel-order model predicts grants,
// expected beats are queued and a negedge monitor checks what the output stage presents.
module tb_mux_rr_n;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [1:0]     out_sel;

  mux_rr_n #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   sel;
  } beat_t;

  beat_t q[$];
  beat_t pend_b;
  bit    pend;
  int    ptr;
  int    checks;
  int    errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: commit last cycle's predicted transfer, drive inputs, predict this cycle.
  task automatic cyc(input logic [N-1:0] vmask, input logic [N*W-1:0] dat, input logic rdy);
    int g;
    int base;
    bit load;
    logic [N-1:0] exp_rdy;
    @(posedge clk);
    if (pend) begin
      q.push_back(pend_b);
      ptr  = (int'(pend_b.sel) == N-1) ? 0 : int'(pend_b.sel) + 1;
      pend = 0;
    end
    #1;
    in_valid  = vmask;
    in_data   = dat;
    out_ready = rdy;
    #1;
`ifdef MUX_FIXED_PRIO_EN
    base = 0;
`else
    base = ptr;
`endif
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && vmask[(base + k) % N]) g = (base + k) % N;
    load    = (q.size() == 0) || rdy;
    exp_rdy = '0;
    if (g >= 0 && load) begin
      exp_rdy[g] = 1'b1;
      pend       = 1;
      pend_b.d   = dat[g*W +: W];
      pend_b.sel = 2'(g);
    end
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_sel",   32'(out_sel),   32'd0);
    q.delete();
    pend = 0;
    ptr  = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: whatever the output stage holds must be the oldest unconsumed predicted beat.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        if (out_valid) begin
          chk("out_data", 32'(out_data), 32'(q[0].d));
          chk("out_sel",  32'(out_sel),  32'(q[0].sel));
        end
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    checks = 0; errors = 0; pend = 0; ptr = 0;
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
    #2;
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_out_data",  32'(out_data),  32'd0);
    chk("init_out_sel",   32'(out_sel),   32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single channel 2 carrying A5.
    cyc(4'b0100, 32'h00A5_0000, 1'b1);
    cyc(4'b0000, 32'h0, 1'b1);
    cyc(4'b0000, 32'h0, 1'b1);

    // All valid: grants walk 3(ptr after ch2),0,1,2,... with matching data.
    for (int i = 0; i < 8; i++) cyc(4'b1111, 32'h1312_1110, 1'b1);
    cyc(4'b0000, 32'h0, 1'b1);

    // Stall with ch1 and ch3 valid, then release.
    cyc(4'b1111, $urandom(), 1'b1);
    for (int i = 0; i < 3; i++) cyc(4'b1010, $urandom(), 1'b0);
    for (int i = 0; i < 3; i++) cyc(4'b1010, $urandom(), 1'b1);
    cyc(4'b0000, 32'h0, 1'b1);

    // Only ch3, with idle gaps between beats.
    for (int i = 0; i < 4; i++) begin
      cyc(4'b1000, $urandom(), 1'b1);
      cyc(4'b0000, $urandom(), 1'b1);
    end

    // Mid-stream reset while a beat is held, then all valid must grant channel 0 first.
    cyc(4'b0110, $urandom(), 1'b0);
    cyc(4'b0110, $urandom(), 1'b0);
    do_reset();
    cyc(4'b1111, $urandom(), 1'b1);
    cyc(4'b1111, $urandom(), 1'b1);

    // Random traffic with a second reset partway through.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cyc(N'($urandom()), $urandom(), ($urandom_range(0, 3) != 0));
    end

    for (int i = 0; i < 4; i++) cyc(4'b0000, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
